// File: rtl/tag_responder.sv
// Tagged-request responder. Requests are parked in a small table for a
// fixed LATENCY, then handed out through a registered response slot.
// Tags already in the table or in the response slot are refused, so each
// tag is outstanding at most once.

// One table entry: holds tag/payload and counts down to eligibility.
module tag_responder_entry #(
  parameter int WIDTH     = 64,
  parameter int TAG_WIDTH = 4,
  parameter int CNT_WIDTH = 8,
  parameter int LATENCY   = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 alloc,
  input  logic                 clear,
  input  logic [TAG_WIDTH-1:0] in_tag,
  input  logic [WIDTH-1:0]     in_data,
  output logic                 valid,
  output logic [TAG_WIDTH-1:0] tag,
  output logic [WIDTH-1:0]     data,
  output logic                 eligible
);
  logic                 valid_q, valid_d;
  logic [TAG_WIDTH-1:0] tag_q, tag_d;
  logic [WIDTH-1:0]     data_q, data_d;
  logic [CNT_WIDTH-1:0] cnt_q, cnt_d;

  // Next state: count down while occupied; alloc and clear never target the
  // same entry in one cycle (alloc picks a free entry, clear a valid one).
  always_comb begin
    valid_d = valid_q;
    tag_d   = tag_q;
    data_d  = data_q;
    cnt_d   = cnt_q;
    if (valid_q && cnt_q != '0) cnt_d = cnt_q - CNT_WIDTH'(1);
    if (clear) valid_d = 1'b0;
    if (alloc) begin
      valid_d = 1'b1;
      tag_d   = in_tag;
      data_d  = in_data;
      cnt_d   = CNT_WIDTH'(LATENCY);
    end
  end

  // Entry state register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      valid_q <= 1'b0;
      tag_q   <= '0;
      data_q  <= '0;
      cnt_q   <= '0;
    end else begin
      valid_q <= valid_d;
      tag_q   <= tag_d;
      data_q  <= data_d;
      cnt_q   <= cnt_d;
    end
  end

  // An occupied entry must never be overwritten.
  always @(posedge clk) begin
    if (!reset) assert (!(alloc && valid_q));
  end

  assign valid    = valid_q;
  assign tag      = tag_q;
  assign data     = data_q;
  assign eligible = valid_q && (cnt_q == '0);
endmodule

module tag_responder #(
  parameter int WIDTH     = 64,
  parameter int TAG_WIDTH = 4,
  parameter int DEPTH     = 4,
  parameter int LOG_DEPTH = 2,
  parameter int LATENCY   = 4,
  parameter int CNT_WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 req_valid,
  output logic                 req_ready,
  input  logic [TAG_WIDTH-1:0] req_tag,
  input  logic [WIDTH-1:0]     req_data,
  output logic                 resp_valid,
  input  logic                 resp_ready,
  output logic [TAG_WIDTH-1:0] resp_tag,
  output logic [WIDTH-1:0]     resp_data,
  output logic [LOG_DEPTH:0]   occupancy
);
  logic [DEPTH-1:0]                ent_valid, ent_elig, alloc_oh, clear_oh;
  logic [DEPTH-1:0][TAG_WIDTH-1:0] ent_tag;
  logic [DEPTH-1:0][WIDTH-1:0]     ent_data;

  logic                 out_valid_q, out_valid_d;
  logic [TAG_WIDTH-1:0] out_tag_q, out_tag_d;
  logic [WIDTH-1:0]     out_data_q, out_data_d;

  logic                 dup, full, free_found, elig_found, can_move;
  logic [TAG_WIDTH-1:0] sel_tag;
  logic [WIDTH-1:0]     sel_data;
  logic [LOG_DEPTH:0]   occ;

  for (genvar g = 0; g < DEPTH; g++) begin : g_ent
    tag_responder_entry #(
      .WIDTH(WIDTH), .TAG_WIDTH(TAG_WIDTH),
      .CNT_WIDTH(CNT_WIDTH), .LATENCY(LATENCY)
    ) u_ent (
      .clk      (clk),
      .reset    (reset),
      .alloc    (alloc_oh[g]),
      .clear    (clear_oh[g]),
      .in_tag   (req_tag),
      .in_data  (req_data),
      .valid    (ent_valid[g]),
      .tag      (ent_tag[g]),
      .data     (ent_data[g]),
      .eligible (ent_elig[g])
    );
  end

  // Admission: refuse when full or when the tag is still outstanding anywhere
  // (table or response slot); grant goes to the lowest free entry. Decided
  // from registered state only, so a same-cycle move does not free a slot.
  always_comb begin
    dup = out_valid_q && (out_tag_q == req_tag);
    for (int i = 0; i < DEPTH; i++)
      if (ent_valid[i] && ent_tag[i] == req_tag) dup = 1'b1;
    full       = &ent_valid;
    req_ready  = !full && !dup;
    alloc_oh   = '0;
    free_found = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if (!free_found && !ent_valid[i]) begin
        free_found  = 1'b1;
        alloc_oh[i] = req_valid && req_ready;
      end
    end
  end

  // Drain: lowest eligible entry moves into the response slot whenever the
  // slot is empty or being consumed this cycle.
  always_comb begin
    can_move   = !out_valid_q || resp_ready;
    clear_oh   = '0;
    elig_found = 1'b0;
    sel_tag    = '0;
    sel_data   = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (!elig_found && ent_elig[i]) begin
        elig_found  = 1'b1;
        clear_oh[i] = can_move;
        sel_tag     = ent_tag[i];
        sel_data    = ent_data[i];
      end
    end
    out_valid_d = out_valid_q;
    out_tag_d   = out_tag_q;
    out_data_d  = out_data_q;
    if (can_move && elig_found) begin
      out_valid_d = 1'b1;
      out_tag_d   = sel_tag;
      out_data_d  = sel_data;
    end else if (out_valid_q && resp_ready) begin
      out_valid_d = 1'b0;
    end
  end

  // Response slot register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_valid_q <= 1'b0;
      out_tag_q   <= '0;
      out_data_q  <= '0;
    end else begin
      out_valid_q <= out_valid_d;
      out_tag_q   <= out_tag_d;
      out_data_q  <= out_data_d;
    end
  end

  // Table occupancy, response slot not counted.
  always_comb begin
    occ = '0;
    for (int i = 0; i < DEPTH; i++) occ = occ + (LOG_DEPTH+1)'(ent_valid[i]);
  end

  // A zero or oversized load value would never count down correctly.
  always @(posedge clk) begin
    assert (LATENCY >= 1 && LATENCY < (1 << CNT_WIDTH));
  end

  assign resp_valid = out_valid_q;
  assign resp_tag   = out_tag_q;
  assign resp_data  = out_data_q;
  assign occupancy  = occ;
endmodule

// File: tb/tb_tag_responder.sv
// Bench for tag_responder: directed scenarios plus random traffic, all
// compared each cycle against a timestamp-based reference model.
module tb_tag_responder;
  localparam int WIDTH = 64, TW = 4, DEPTH = 4, LD = 2, LAT = 4;

  logic clk = 1'b0, reset = 1'b1;
  always #5 clk = ~clk;

  logic          req_valid = 0, req_ready, resp_valid, resp_ready = 0;
  logic [TW-1:0] req_tag = '0, resp_tag;
  logic [63:0]   req_data = '0, resp_data;
  logic [LD:0]   occupancy;

  logic          s_req_valid = 0, s_req_ready, s_resp_valid, s_resp_ready = 1;
  logic [TW-1:0] s_req_tag = '0, s_resp_tag;
  logic [63:0]   s_req_data = '0, s_resp_data;
  logic [LD:0]   s_occ;

  tag_responder #(.WIDTH(WIDTH), .TAG_WIDTH(TW), .DEPTH(DEPTH), .LOG_DEPTH(LD),
                  .LATENCY(LAT), .CNT_WIDTH(8)) u_dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
    .req_tag(req_tag), .req_data(req_data), .resp_valid(resp_valid),
    .resp_ready(resp_ready), .resp_tag(resp_tag), .resp_data(resp_data),
    .occupancy(occupancy));

  tag_responder #(.WIDTH(WIDTH), .TAG_WIDTH(TW), .DEPTH(DEPTH), .LOG_DEPTH(LD),
                  .LATENCY(1), .CNT_WIDTH(8)) u_dut1 (
    .clk(clk), .reset(reset), .req_valid(s_req_valid), .req_ready(s_req_ready),
    .req_tag(s_req_tag), .req_data(s_req_data), .resp_valid(s_resp_valid),
    .resp_ready(s_resp_ready), .resp_tag(s_resp_tag), .resp_data(s_resp_data),
    .occupancy(s_occ));

  int errors = 0, checks = 0;

  task automatic chk(input string nm, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", nm, obs, exp);
    end
  endtask

  // Reference model: each request remembers the edge it was accepted on and
  // becomes eligible LAT+1 edges later; the slot index only sets priority.
  bit          m_v[DEPTH];
  logic [TW-1:0] m_tag[DEPTH];
  logic [63:0] m_data[DEPTH];
  int          m_t[DEPTH];
  bit          m_ov;
  logic [TW-1:0] m_otag;
  logic [63:0] m_odata;
  int          edge_n = 0;

  function automatic int m_count();
    int n = 0;
    for (int i = 0; i < DEPTH; i++) n += int'(m_v[i]);
    return n;
  endfunction

  function automatic bit m_ready(input logic [TW-1:0] t);
    if (m_count() == DEPTH) return 1'b0;
    if (m_ov && m_otag == t) return 1'b0;
    for (int i = 0; i < DEPTH; i++) if (m_v[i] && m_tag[i] == t) return 1'b0;
    return 1'b1;
  endfunction

  task automatic model_clear();
    for (int i = 0; i < DEPTH; i++) begin
      m_v[i] = 0; m_tag[i] = '0; m_data[i] = '0; m_t[i] = 0;
    end
    m_ov = 0; m_otag = '0; m_odata = '0;
  endtask

  task automatic model_edge();
    bit acc; int f, j;
    acc = req_valid && m_ready(req_tag);
    f = -1; j = -1;
    for (int i = DEPTH-1; i >= 0; i--) begin
      if (!m_v[i]) f = i;
      if (m_v[i] && edge_n >= m_t[i] + LAT + 1) j = i;
    end
    if (j >= 0 && (!m_ov || resp_ready)) begin
      m_ov = 1; m_otag = m_tag[j]; m_odata = m_data[j]; m_v[j] = 0;
    end else if (m_ov && resp_ready) begin
      m_ov = 0;
    end
    if (acc) begin
      m_v[f] = 1; m_tag[f] = req_tag; m_data[f] = req_data; m_t[f] = edge_n;
    end
  endtask

  task automatic model_check();
    chk("req_ready", req_ready, m_ready(req_tag));
    chk("resp_valid", resp_valid, m_ov);
    chk("resp_tag", resp_tag, m_otag);
    chk("resp_data", resp_data, m_odata);
    chk("occupancy", occupancy, m_count());
  endtask

  // One clock: compare at negedge, advance model, return 1 time unit past posedge.
  task automatic cycle();
    @(negedge clk);
    model_check();
    if (reset) model_clear(); else model_edge();
    edge_n++;
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    req_valid = 0; resp_ready = 1;
    repeat (12) cycle();
    chk("drain_occ", occupancy, 0);
    chk("drain_valid", resp_valid, 0);
  endtask

  initial begin
    bit hit;
    model_clear();

    // Reset held for three cycles.
    repeat (3) cycle();
    chk("rst_valid", resp_valid, 0);
    chk("rst_ready", req_ready, 1);
    chk("rst_occ", occupancy, 0);
    chk("rst_tag", resp_tag, 0);
    chk("rst_data", resp_data, 0);
    reset = 0;

    // Single request, idle output: response visible after LAT+1 edges, one cycle.
    resp_ready = 1; req_valid = 1; req_tag = 3; req_data = 64'hABC;
    cycle();
    req_valid = 0;
    for (int k = 1; k <= 6; k++) begin
      cycle();
      chk($sformatf("single_valid_k%0d", k), resp_valid, (k == 5));
      chk($sformatf("single_occ_k%0d", k), occupancy, (k < 5) ? 1 : 0);
      if (k == 5) begin
        chk("single_tag", resp_tag, 3);
        chk("single_data", resp_data, 64'hABC);
      end
    end

    // Fill with backpressure.
    resp_ready = 0;
    for (int k = 0; k < 4; k++) begin
      req_valid = 1; req_tag = TW'(k); req_data = 64'(100 + k);
      cycle();
    end
    req_tag = 4; req_data = 64'h44; #1;
    chk("full_ready", req_ready, 0);
    chk("full_occ", occupancy, 4);
    hit = 0;
    for (int k = 0; k < 10 && !hit; k++) begin
      cycle();
      if (occupancy == 3) hit = 1;
    end
    chk("fill_move_seen", hit, 1);
    req_tag = 0; #1;
    chk("fill_tag0_blocked", req_ready, 0);
    chk("fill_out_tag", resp_tag, 0);
    req_tag = 4; #1;
    chk("fill_tag4_ready", req_ready, 1);
    cycle();
    chk("fill_tag4_occ", occupancy, 4);
    drain();

    // Duplicate tag handling.
    req_valid = 1; req_tag = 5; req_data = 64'h55;
    cycle();
    #1 chk("dup_ready", req_ready, 0);
    cycle();
    chk("dup_occ", occupancy, 1);
    req_tag = 6; req_data = 64'h66; #1;
    chk("dup_other_ready", req_ready, 1);
    cycle();
    chk("dup_other_occ", occupancy, 2);
    req_valid = 0; req_tag = 5;
    hit = 0;
    for (int k = 0; k < 20 && !hit; k++) begin
      cycle();
      if (resp_valid && resp_tag == 5) hit = 1;
    end
    chk("dup_resp_seen", hit, 1);
    chk("dup_in_slot_blocked", req_ready, 0);
    cycle();
    chk("dup_unblocked", req_ready, 1);
    req_valid = 1; req_data = 64'h555;
    cycle();
    chk("dup_reaccept_occ", occupancy, 1);
    drain();

    // Backpressure: held response is stable, then queue drains back to back.
    resp_ready = 0;
    req_valid = 1; req_tag = 1; req_data = 64'hD1;
    cycle();
    req_valid = 0;
    repeat (6) cycle();
    for (int k = 2; k <= 4; k++) begin
      req_valid = 1; req_tag = TW'(k); req_data = 64'(208 + k);
      cycle();
    end
    req_valid = 0;
    repeat (6) cycle();
    for (int k = 0; k < 10; k++) begin
      cycle();
      chk("bp_valid", resp_valid, 1);
      chk("bp_tag", resp_tag, 1);
      chk("bp_data", resp_data, 64'hD1);
    end
    resp_ready = 1;
    for (int k = 2; k <= 4; k++) begin
      cycle();
      chk("bp_rel_valid", resp_valid, 1);
      chk("bp_rel_tag", resp_tag, k);
      chk("bp_rel_data", resp_data, 208 + k);
    end
    cycle();
    chk("bp_rel_done", resp_valid, 0);

    // Mid-cycle reset with two entries valid.
    req_valid = 1; req_tag = 7; req_data = 64'h77; cycle();
    req_tag = 8; req_data = 64'h88; cycle();
    req_valid = 0;
    chk("mrst_pre_occ", occupancy, 2);
    reset = 1; #1;
    chk("mrst_occ", occupancy, 0);
    chk("mrst_valid", resp_valid, 0);
    chk("mrst_ready", req_ready, 1);
    model_clear();
    cycle();
    reset = 0;
    req_valid = 1; req_tag = 7; cycle();
    chk("mrst_accept", occupancy, 1);
    drain();

    // Streaming on the LATENCY=1 instance.
    s_resp_ready = 1;
    for (int n = 0; n < 12; n++) begin
      s_req_valid = (n < 8); s_req_tag = TW'(n); s_req_data = 64'(32'hC0 + n);
      if (n < 8) #1 chk("strm_ready", s_req_ready, 1);
      cycle();
      chk("strm_valid", s_resp_valid, (n >= 2 && n <= 9));
      if (n >= 2 && n <= 9) begin
        chk("strm_tag", s_resp_tag, n - 2);
        chk("strm_data", s_resp_data, 32'hC0 + n - 2);
      end
    end
    s_req_valid = 0;

    // Random traffic with frequent duplicate tags and backpressure.
    for (int n = 0; n < 600; n++) begin
      req_valid  = ($urandom_range(0, 3) != 0);
      req_tag    = TW'($urandom_range(0, 7));
      req_data   = {$urandom, $urandom};
      resp_ready = ($urandom_range(0, 9) < 7);
      cycle();
    end
    drain();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
